// File: rtl/vcell_access_arbiter.sv
// Velocity cell access arbiter: shares the single write port and single read
// port of the velocity cell memory between the motion-update unit (MU) and the
// velocity loader (LD). INIT gives LD exclusive access until its last load
// write; RUN then arbitrates round-robin independently on each port.
module vcell_access_arbiter #(
    parameter int FLOAT_STRUCT_WIDTH = 96,
    parameter int PARTICLE_ID_WIDTH  = 7,
    parameter int RD_LATENCY         = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          mu_wr_valid,
    output logic                          mu_wr_ready,
    input  logic [PARTICLE_ID_WIDTH-1:0]  mu_wr_addr,
    input  logic [FLOAT_STRUCT_WIDTH-1:0] mu_wr_data,
    input  logic                          mu_rd_valid,
    output logic                          mu_rd_ready,
    input  logic [PARTICLE_ID_WIDTH-1:0]  mu_rd_addr,
    output logic                          mu_rsp_valid,
    output logic [FLOAT_STRUCT_WIDTH-1:0] mu_rsp_data,
    input  logic                          ld_wr_valid,
    output logic                          ld_wr_ready,
    input  logic [PARTICLE_ID_WIDTH-1:0]  ld_wr_addr,
    input  logic [FLOAT_STRUCT_WIDTH-1:0] ld_wr_data,
    input  logic                          ld_wr_last,
    input  logic                          ld_rd_valid,
    output logic                          ld_rd_ready,
    input  logic [PARTICLE_ID_WIDTH-1:0]  ld_rd_addr,
    output logic                          ld_rsp_valid,
    output logic [FLOAT_STRUCT_WIDTH-1:0] ld_rsp_data,
    output logic [FLOAT_STRUCT_WIDTH-1:0] vel_in_0,
    output logic [PARTICLE_ID_WIDTH-1:0]  wr_addr_0,
    output logic                          wr_en_0,
    output logic [PARTICLE_ID_WIDTH-1:0]  rd_addr_0,
    input  logic [FLOAT_STRUCT_WIDTH-1:0] vel_out_0,
    output logic                          init_done
);

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} phase_t;
    localparam logic PREF_MU = 1'b0;
    localparam logic PREF_LD = 1'b1;

    phase_t                          r_state;
    phase_t                          w_state_nxt;
    logic                            w_in_run;
    logic                            r_rr_wr;
    logic                            r_rr_rd;
    logic                            w_mu_wr_gnt;
    logic                            w_ld_wr_gnt;
    logic                            w_mu_rd_gnt;
    logic                            w_ld_rd_gnt;
    logic                            w_wr_fire;
    logic                            w_rd_req;
    logic                            w_rd_hazard;
    logic                            w_rd_fire;
    logic [PARTICLE_ID_WIDTH-1:0]    w_wr_addr;
    logic [FLOAT_STRUCT_WIDTH-1:0]   w_wr_data;
    logic [PARTICLE_ID_WIDTH-1:0]    w_rd_addr;
    logic                            r_wr_en;
    logic [PARTICLE_ID_WIDTH-1:0]    r_wr_addr;
    logic [FLOAT_STRUCT_WIDTH-1:0]   r_vel_in;
    logic [PARTICLE_ID_WIDTH-1:0]    r_rd_addr;
    logic [RD_LATENCY:0]             r_pipe_vld;
    logic [RD_LATENCY:0]             r_pipe_own_ld;
    logic                            w_tail_vld;
    logic [FLOAT_STRUCT_WIDTH-1:0]   r_mu_rsp_hold;
    logic [FLOAT_STRUCT_WIDTH-1:0]   r_ld_rsp_hold;

    // Phase state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_INIT;
        else     r_state <= w_state_nxt;
    end

    // Leave INIT once LD's final load write is accepted; RUN is sticky
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_INIT && ld_wr_valid && ld_wr_ready && ld_wr_last)
            w_state_nxt = ST_RUN;
    end

    // Phase outputs
    always_comb begin
        w_in_run  = (r_state == ST_RUN);
        init_done = w_in_run;
    end

    // Grant selection: LD owns both ports in INIT, round-robin per port in RUN
    always_comb begin
        w_mu_wr_gnt = 1'b0;
        w_ld_wr_gnt = 1'b0;
        w_mu_rd_gnt = 1'b0;
        w_ld_rd_gnt = 1'b0;
        if (w_in_run) begin
            w_mu_wr_gnt = mu_wr_valid && (!ld_wr_valid || r_rr_wr == PREF_MU);
            w_ld_wr_gnt = ld_wr_valid && (!mu_wr_valid || r_rr_wr == PREF_LD);
            w_mu_rd_gnt = mu_rd_valid && (!ld_rd_valid || r_rr_rd == PREF_MU);
            w_ld_rd_gnt = ld_rd_valid && (!mu_rd_valid || r_rr_rd == PREF_LD);
        end else begin
            w_ld_wr_gnt = 1'b1;
            w_ld_rd_gnt = 1'b1;
        end
    end

    // Port muxing and same-address hazard: the write wins, the read retries
    always_comb begin
        w_wr_fire   = (mu_wr_valid && w_mu_wr_gnt) || (ld_wr_valid && w_ld_wr_gnt);
        w_wr_addr   = w_mu_wr_gnt ? mu_wr_addr : ld_wr_addr;
        w_wr_data   = w_mu_wr_gnt ? mu_wr_data : ld_wr_data;
        w_rd_req    = (mu_rd_valid && w_mu_rd_gnt) || (ld_rd_valid && w_ld_rd_gnt);
        w_rd_addr   = w_mu_rd_gnt ? mu_rd_addr : ld_rd_addr;
        w_rd_hazard = w_wr_fire && w_rd_req && (w_wr_addr == w_rd_addr);
        w_rd_fire   = w_rd_req && !w_rd_hazard;
        mu_wr_ready = w_mu_wr_gnt;
        ld_wr_ready = w_ld_wr_gnt;
        mu_rd_ready = w_mu_rd_gnt && !w_rd_hazard;
        ld_rd_ready = w_ld_rd_gnt && !w_rd_hazard;
    end

    // Round-robin pointers: after any accepted grant, prefer the other side
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_wr <= PREF_MU;
            r_rr_rd <= PREF_MU;
        end else if (w_in_run) begin
            if (w_wr_fire) r_rr_wr <= w_mu_wr_gnt ? PREF_LD : PREF_MU;
            if (w_rd_fire) r_rr_rd <= w_mu_rd_gnt ? PREF_LD : PREF_MU;
        end
    end

    // Registered memory-side write and read address
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_vel_in  <= '0;
            r_rd_addr <= '0;
        end else begin
            r_wr_en <= w_wr_fire;
            if (w_wr_fire) begin
                r_wr_addr <= w_wr_addr;
                r_vel_in  <= w_wr_data;
            end
            if (w_rd_fire) r_rd_addr <= w_rd_addr;
        end
    end

    assign wr_en_0   = r_wr_en;
    assign wr_addr_0 = r_wr_addr;
    assign vel_in_0  = r_vel_in;
    assign rd_addr_0 = r_rd_addr;

    // Read-owner tracking: bit 0 covers the address cycle, the tail meets memory data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe_vld    <= '0;
            r_pipe_own_ld <= '0;
        end else begin
            r_pipe_vld    <= {r_pipe_vld[RD_LATENCY-1:0], w_rd_fire};
            r_pipe_own_ld <= {r_pipe_own_ld[RD_LATENCY-1:0], !w_mu_rd_gnt};
        end
    end

    // Response steering; rst masks the tail so nothing escapes a reset
    always_comb begin
        w_tail_vld   = r_pipe_vld[RD_LATENCY] && !rst;
        mu_rsp_valid = w_tail_vld && !r_pipe_own_ld[RD_LATENCY];
        ld_rsp_valid = w_tail_vld && r_pipe_own_ld[RD_LATENCY];
        mu_rsp_data  = mu_rsp_valid ? vel_out_0 : r_mu_rsp_hold;
        ld_rsp_data  = ld_rsp_valid ? vel_out_0 : r_ld_rsp_hold;
    end

    // Each requester's data output holds its most recent response
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mu_rsp_hold <= '0;
            r_ld_rsp_hold <= '0;
        end else begin
            if (mu_rsp_valid) r_mu_rsp_hold <= vel_out_0;
            if (ld_rsp_valid) r_ld_rsp_hold <= vel_out_0;
        end
    end

endmodule
